uart_alu_bridge: RTL and testbench

UART_ALU_BRIDGE -- requirements
Module: uart_alu_bridge

---
 rtl/uart_alu_bridge.sv | 177 +++++++++++++++++
 tb/tb_uart_alu_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_bridge.sv
// Byte-serial front end for an external ALU: collects A, B and opcode from a
// UART receiver, then sends the ALU result back out one byte at a time.
module uart_alu_bridge #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter bit          MSB_FIRST   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [7:0]        opcode,
  output logic              busy,
  output logic              frame_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(BYTES) + 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_RELOAD = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);

  typedef enum logic [2:0] {
    RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0] sha_q, sha_d;
  logic [DATA_W-1:0] shb_q, shb_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [7:0]        op_q, op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              frame_err_q, frame_err_d;

  logic              busy_int;
  logic              accept;
  logic              last;
  logic              tmo_run;
  logic              expire;
  logic [CNT_W-1:0]  lane;

  always_comb begin
    busy_int = (state_q == EXEC) || (state_q == TX_SEND) || (state_q == TX_WAIT);
    accept   = rx_done && !busy_int;
    last     = (cnt_q == LAST_BYTE);
    tmo_run  = ((state_q == RX_A) && (cnt_q != '0)) ||
               (state_q == RX_B) || (state_q == RX_OP);
    // A byte arriving on the expiry cycle wins over the timeout.
    expire   = (TIMEOUT_CYC != 0) && tmo_run && !rx_done && (tmo_q == TO_ONE);
    lane     = MSB_FIRST ? (LAST_BYTE - cnt_q) : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RX_A;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_A:    if (accept && last) state_d = RX_B;
      RX_B:    if (accept && last) state_d = RX_OP;
      RX_OP:   if (accept) state_d = EXEC;
      EXEC:    state_d = TX_SEND;
      TX_SEND: state_d = TX_WAIT;
      TX_WAIT: if (tx_done) state_d = last ? RX_A : TX_SEND;
      default: state_d = RX_A;
    endcase
    if (expire) state_d = RX_A;
  end

  always_comb begin
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    sha_d       = sha_q;
    shb_d       = shb_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    frame_err_d = 1'b0;
    case (state_q)
      RX_A, RX_B: begin
        if (accept) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if (lane == CNT_W'(i)) begin
              if (state_q == RX_A) sha_d[8*i +: 8] = rx_data;
              else                 shb_d[8*i +: 8] = rx_data;
            end
          end
          cnt_d = last ? '0 : cnt_q + CNT_ONE;
          tmo_d = TO_RELOAD;
        end
      end
      RX_OP: begin
        if (accept) begin
          a_d   = sha_q;
          b_d   = shb_q;
          op_d  = rx_data;
          sha_d = '0;
          shb_d = '0;
          tmo_d = '0;
        end
      end
      EXEC: begin
        res_d = alu_result;
        cnt_d = '0;
      end
      TX_WAIT: begin
        if (tx_done) begin
          res_d = MSB_FIRST ? (res_q << 8) : (res_q >> 8);
          cnt_d = last ? '0 : cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
    if (expire) begin
      frame_err_d = 1'b1;
      cnt_d       = '0;
      sha_d       = '0;
      shb_d       = '0;
      tmo_d       = '0;
    end else if ((TIMEOUT_CYC != 0) && tmo_run && !accept) begin
      tmo_d = tmo_q - TO_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      tmo_q       <= '0;
      sha_q       <= '0;
      shb_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      sha_q       <= sha_d;
      shb_q       <= shb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    tx_start  = (state_q == TX_SEND);
    busy      = busy_int;
    tx_data   = MSB_FIRST ? res_q[DATA_W-1 -: 8] : res_q[7:0];
    a         = a_q;
    b         = b_q;
    opcode    = op_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_uart_alu_bridge.sv
// Directed bench: three bridge configurations share the UART-side stimulus;
// each scenario resets them and checks only the instance it targets.
module tb_uart_alu_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;

  logic [31:0] alu0 = '0, a0, b0;
  logic [7:0]  tx_data0, op0;
  logic        tx_start0, busy0, ferr0;

  logic [31:0] alu1 = '0, a1, b1;
  logic [7:0]  tx_data1, op1;
  logic        tx_start1, busy1, ferr1;

  logic [15:0] alu2 = '0, a2, b2;
  logic [7:0]  tx_data2, op2;
  logic        tx_start2, busy2, ferr2;

  int checks = 0;
  int errors = 0;
  int ts_cnt0 = 0, ts_cnt2 = 0, ferr_cnt0 = 0, ferr_cnt2 = 0;

  always #5 clk = ~clk;

  uart_alu_bridge #(.DATA_W(32), .TIMEOUT_CYC(100), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .alu_result(alu0), .tx_data(tx_data0), .tx_start(tx_start0), .a(a0), .b(b0),
    .opcode(op0), .busy(busy0), .frame_err(ferr0));

  uart_alu_bridge #(.DATA_W(32), .TIMEOUT_CYC(0), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .alu_result(alu1), .tx_data(tx_data1), .tx_start(tx_start1), .a(a1), .b(b1),
    .opcode(op1), .busy(busy1), .frame_err(ferr1));

  uart_alu_bridge #(.DATA_W(16), .TIMEOUT_CYC(20), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
    .alu_result(alu2), .tx_data(tx_data2), .tx_start(tx_start2), .a(a2), .b(b2),
    .opcode(op2), .busy(busy2), .frame_err(ferr2));

  always @(posedge clk) begin
    if (tx_start0) ts_cnt0 <= ts_cnt0 + 1;
    if (tx_start2) ts_cnt2 <= ts_cnt2 + 1;
    if (ferr0)     ferr_cnt0 <= ferr_cnt0 + 1;
    if (ferr2)     ferr_cnt2 <= ferr_cnt2 + 1;
  end

  function automatic logic get_start(input int idx);
    case (idx)
      0:       return tx_start0;
      1:       return tx_start1;
      default: return tx_start2;
    endcase
  endfunction

  function automatic logic get_busy(input int idx);
    case (idx)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic [7:0] get_data(input int idx);
    case (idx)
      0:       return tx_data0;
      1:       return tx_data1;
      default: return tx_data2;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // bytes[7:0] goes out first.
  task automatic send_bytes(input logic [71:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      rx_data = bytes[8*i +: 8];
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  // Entered on the negedge where a tx_start is expected; exp[7:0] is the first byte.
  task automatic tx_check(input int idx, input int nbytes, input logic [63:0] exp,
                          input bit inject, input bit bogus, input int stop_after);
    for (int i = 0; i < stop_after; i++) begin
      checks++;
      if (get_start(idx) !== 1'b1 || get_data(idx) !== exp[8*i +: 8]) begin
        errors++;
        $display("FAIL tx_byte%0d inst%0d: start=%b data=%h, expected start=1 data=%h",
                 i, idx, get_start(idx), get_data(idx), exp[8*i +: 8]);
      end
      if (bogus && i == 0) tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (inject) begin
        rx_data = 8'hFF;
        rx_done = 1'b1;
      end
      @(negedge clk);
      rx_done = 1'b0;
      checks++;
      if (get_start(idx) !== 1'b0 || get_busy(idx) !== 1'b1 || get_data(idx) !== exp[8*i +: 8]) begin
        errors++;
        $display("FAIL tx_wait_hold%0d inst%0d: start=%b busy=%b data=%h, expected start=0 busy=1 data=%h",
                 i, idx, get_start(idx), get_busy(idx), get_data(idx), exp[8*i +: 8]);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      if (i == nbytes - 1) begin
        checks++;
        if (get_busy(idx) !== 1'b0 || get_start(idx) !== 1'b0) begin
          errors++;
          $display("FAIL tx_end inst%0d: busy=%b start=%b, expected busy=0 start=0",
                   idx, get_busy(idx), get_start(idx));
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start0, busy0, ferr0, tx_data0, op0, a0, b0} !== '0 ||
        {tx_start1, busy1, ferr1, tx_data1, op1, a1, b1} !== '0 ||
        {tx_start2, busy2, ferr2, tx_data2, op2, a2, b2} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: u0 a=%h b=%h op=%h txd=%h st=%b busy=%b ferr=%b, expected all 0",
               a0, b0, op0, tx_data0, tx_start0, busy0, ferr0);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    alu0 = 32'h0000_0008;
    send_bytes(72'h00_00_00_00_03_00_00_00_05, 8);
    checks++;
    if (a0 !== 32'h0 || b0 !== 32'h0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_shadow: a=%h b=%h busy=%b, expected a=0 b=0 busy=0", a0, b0, busy0);
    end
    send_bytes(72'h20, 1);
    checks++;
    if (a0 !== 32'h5 || b0 !== 32'h3 || op0 !== 8'h20 || busy0 !== 1'b1 || tx_start0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_exec: a=%h b=%h op=%h busy=%b st=%b, expected a=5 b=3 op=20 busy=1 st=0",
               a0, b0, op0, busy0, tx_start0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    tx_check(0, 4, 64'h0000_0000_0000_0008, 1'b0, 1'b1, 4);
  endtask

  task automatic test_msb_first();
    do_reset();
    alu1 = 32'hAABB_CCDD;
    send_bytes(72'h22_01_00_00_00_78_56_34_12, 9);
    checks++;
    if (a1 !== 32'h1234_5678 || b1 !== 32'h0000_0001 || op1 !== 8'h22) begin
      errors++;
      $display("FAIL msb_decode: a=%h b=%h op=%h, expected a=12345678 b=00000001 op=22", a1, b1, op1);
    end
    @(negedge clk);
    tx_check(1, 4, 64'h0000_0000_DDCC_BBAA, 1'b0, 1'b0, 4);
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    alu0 = 32'h0000_0008;
    send_bytes(72'h20_00_00_00_03_00_00_00_05, 9);
    @(negedge clk);
    tx_check(0, 4, 64'h0000_0000_0000_0008, 1'b0, 1'b0, 4);
    base = ferr_cnt0;
    send_bytes(72'h33_22_11, 3);
    repeat (99) @(negedge clk);
    checks++;
    if (ferr0 !== 1'b0 || ferr_cnt0 != base) begin
      errors++;
      $display("FAIL timeout_early: ferr=%b pulses=%0d, expected ferr=0 pulses=0", ferr0, ferr_cnt0 - base);
    end
    @(negedge clk);
    checks++;
    if (ferr0 !== 1'b1 || a0 !== 32'h5 || b0 !== 32'h3 || op0 !== 8'h20) begin
      errors++;
      $display("FAIL timeout_fire: ferr=%b a=%h b=%h op=%h, expected ferr=1 a=5 b=3 op=20",
               ferr0, a0, b0, op0);
    end
    @(negedge clk);
    checks++;
    if (ferr0 !== 1'b0 || ferr_cnt0 - base != 1) begin
      errors++;
      $display("FAIL timeout_single: ferr=%b pulses=%0d, expected ferr=0 pulses=1", ferr0, ferr_cnt0 - base);
    end
    alu0 = 32'h0;
    send_bytes(72'h09_08_07_06_05_04_03_02_01, 9);
    checks++;
    if (a0 !== 32'h0403_0201 || b0 !== 32'h0807_0605 || op0 !== 8'h09) begin
      errors++;
      $display("FAIL timeout_recover: a=%h b=%h op=%h, expected a=04030201 b=08070605 op=09", a0, b0, op0);
    end
    @(negedge clk);
    tx_check(0, 4, 64'h0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_back_to_back();
    do_reset();
    alu0 = 32'h1122_3344;
    send_bytes(72'h21_00_00_00_0B_00_00_00_0A, 9);
    rx_data = 8'hEE;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_check(0, 4, 64'h0000_0000_1122_3344, 1'b1, 1'b0, 4);
    alu0 = 32'h0;
    send_bytes(72'h00_00_00_02_00_00_00_01, 8);
    checks++;
    if (a0 !== 32'h0A || b0 !== 32'h0B || op0 !== 8'h21) begin
      errors++;
      $display("FAIL b2b_hold: a=%h b=%h op=%h, expected a=0000000a b=0000000b op=21", a0, b0, op0);
    end
    send_bytes(72'h30, 1);
    checks++;
    if (a0 !== 32'h1 || b0 !== 32'h2 || op0 !== 8'h30) begin
      errors++;
      $display("FAIL b2b_decode: a=%h b=%h op=%h, expected a=1 b=2 op=30", a0, b0, op0);
    end
    @(negedge clk);
    tx_check(0, 4, 64'h0, 1'b0, 1'b0, 4);
  endtask

  task automatic test_reset_mid_tx();
    int base;
    do_reset();
    alu0 = 32'hDEAD_BEEF;
    send_bytes(72'h20_00_00_00_03_00_00_00_05, 9);
    @(negedge clk);
    tx_check(0, 4, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 1);
    checks++;
    if (tx_start0 !== 1'b1 || tx_data0 !== 8'hBE) begin
      errors++;
      $display("FAIL midtx_second_start: st=%b data=%h, expected st=1 data=be", tx_start0, tx_data0);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_start0 !== 1'b0 || busy0 !== 1'b0 || a0 !== 32'h0 || b0 !== 32'h0 ||
        op0 !== 8'h0 || tx_data0 !== 8'h0) begin
      errors++;
      $display("FAIL midtx_async_reset: st=%b busy=%b a=%h b=%h op=%h txd=%h, expected all 0",
               tx_start0, busy0, a0, b0, op0, tx_data0);
    end
    base = ts_cnt0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ts_cnt0 != base || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL midtx_no_restart: extra_starts=%0d busy=%b, expected 0 and 0", ts_cnt0 - base, busy0);
    end
    send_bytes(72'hFF_FF, 2);
    do_reset();
    alu0 = 32'h0000_0105;
    send_bytes(72'h40_00_00_00_02_00_00_00_07, 9);
    checks++;
    if (a0 !== 32'h7 || b0 !== 32'h2 || op0 !== 8'h40) begin
      errors++;
      $display("FAIL midtx_new_frame: a=%h b=%h op=%h, expected a=7 b=2 op=40", a0, b0, op0);
    end
    @(negedge clk);
    tx_check(0, 4, 64'h0000_0000_0000_0105, 1'b0, 1'b0, 4);
  endtask

  task automatic test_coincide_16();
    int fbase;
    int tbase;
    do_reset();
    alu2 = 16'hBEEF;
    fbase = ferr_cnt2;
    send_bytes(72'h34, 1);
    repeat (19) @(negedge clk);
    send_bytes(72'h12, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (ferr2 !== 1'b0 || ferr_cnt2 != fbase) begin
      errors++;
      $display("FAIL coincide_no_err: ferr=%b pulses=%0d, expected ferr=0 pulses=0", ferr2, ferr_cnt2 - fbase);
    end
    send_bytes(72'h05_56_78, 3);
    checks++;
    if (a2 !== 16'h1234 || b2 !== 16'h5678 || op2 !== 8'h05) begin
      errors++;
      $display("FAIL coincide_decode: a=%h b=%h op=%h, expected a=1234 b=5678 op=05", a2, b2, op2);
    end
    tbase = ts_cnt2;
    @(negedge clk);
    tx_check(2, 2, 64'h0000_0000_0000_BEEF, 1'b0, 1'b0, 2);
    repeat (3) @(negedge clk);
    checks++;
    if (ts_cnt2 - tbase != 2) begin
      errors++;
      $display("FAIL w16_start_count: got %0d pulses, expected 2", ts_cnt2 - tbase);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_msb_first();
    test_timeout();
    test_back_to_back();
    test_reset_mid_tx();
    test_coincide_16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
